// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-side bus bundle for ahb_slave_mem.
// The master drives the address/data phase signals; the slave returns data and response.
interface ahb_slave_mem_if;
    logic        hsel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready_in;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hwdata, hready_in,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hwdata, hready_in,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-addressed memory slave with a fixed number of wait states per OKAY transfer
// and a two-cycle ERROR response for misaligned or out-of-range accesses.
module ahb_slave_mem #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned MEM_DEPTH   = 16
) (
    input  logic clk,
    input  logic rst,
    ahb_slave_mem_if.slave bus
);

    localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0]  WaitLoad = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} state_e;

    state_e          state_q;
    logic [2:0]      cnt_q;
    logic [IdxW-1:0] idx_q;
    logic            write_q;
    logic            hreadyout_q;
    logic [1:0]      hresp_q;
    logic [31:0]     hrdata_q;
    logic [31:0]     mem_q [MEM_DEPTH];

    logic            accept;
    logic            legal;
    logic [IdxW-1:0] new_idx;
    logic [31:0]     fwd_rdata;

    always_comb begin
        accept  = (state_q inside {StIdle, StDone, StErr2}) && bus.hsel && bus.hready_in &&
                  (bus.htrans inside {2'b10, 2'b11});
        legal   = (bus.haddr[1:0] == 2'b00) && (32'(bus.haddr[15:2]) < MEM_DEPTH);
        new_idx = bus.haddr[IdxW+1:2];
        // A zero-wait read pipelined behind a write to the same word sees the data being written.
        if (state_q == StDone && write_q && idx_q == new_idx) begin
            fwd_rdata = bus.hwdata;
        end else begin
            fwd_rdata = mem_q[new_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
            hrdata_q    <= 32'd0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            if (state_q == StDone && write_q) begin
                mem_q[idx_q] <= bus.hwdata;
            end
            hrdata_q <= 32'd0;
            unique case (state_q)
                StIdle, StDone, StErr2: begin
                    if (accept) begin
                        idx_q   <= new_idx;
                        write_q <= bus.hwrite;
                        if (!legal) begin
                            state_q     <= StErr1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 2'b01;
                        end else if (WAIT_STATES > 0) begin
                            state_q     <= StWait;
                            cnt_q       <= WaitLoad;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 2'b00;
                        end else begin
                            state_q     <= StDone;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= 2'b00;
                            hrdata_q    <= bus.hwrite ? 32'd0 : fwd_rdata;
                        end
                    end else begin
                        state_q     <= StIdle;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 2'b00;
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= StDone;
                        hreadyout_q <= 1'b1;
                        hrdata_q    <= write_q ? 32'd0 : mem_q[idx_q];
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StErr1: begin
                    state_q     <= StErr2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 2'b01;
                end
                default: begin
                    state_q     <= StIdle;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 2'b00;
                end
            endcase
        end
    end

    assign bus.hrdata    = hrdata_q;
    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter WAIT_STATES, default 2, SHALL set the number of data-phase wait cycles per OKAY transfer (legal range 0..7).
REQ-002 Parameter MEM_DEPTH, default 16, SHALL set the number of 32-bit words of storage (power of two, at most 64).
REQ-003 Clocking and reset SHALL be fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 hsel  input  1  slave select from the address decoder.
REQ-007 haddr  input  16  byte address (address phase).
REQ-008 htrans  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-009 hwrite  input  1  1 = write, 0 = read (address phase).
REQ-010 hwdata  input  32  write data (data phase).
REQ-011 hready_in  input  1  bus-level ready; address phase completes only when high.
REQ-012 hrdata  output  32  read data.
REQ-013 hreadyout  output  1  slave ready; low inserts wait states.
REQ-014 hresp  output  2  response: 00 OKAY, 01 ERROR (10/11 never driven).

Function
REQ-015 The block SHALL accept a transfer on a rising edge where hsel=1, hready_in=1 and htrans[1]=1, and SHALL register haddr and hwrite.
REQ-016 IDLE and BUSY transfers, or hsel=0, SHALL produce no data phase; hreadyout SHALL stay 1 and hresp SHALL stay 00.
REQ-017 The block SHALL use an FSM with states IDLE, WAIT, DONE, ERR1 and ERR2.
REQ-018 A legal accepted transfer SHALL go to WAIT when WAIT_STATES>0, otherwise to DONE.
REQ-019 An illegal accepted transfer SHALL go to ERR1.
REQ-020 A transfer SHALL be illegal when haddr[1:0]!=00 or when the word index haddr[15:2] is greater than or equal to MEM_DEPTH.
REQ-021 In WAIT, hreadyout=0 and hresp=00; a down-counter loaded with WAIT_STATES-1 SHALL move the FSM to DONE when it reaches 0.
REQ-022 The data phase of a legal transfer SHALL therefore last exactly WAIT_STATES+1 cycles.
REQ-023 In DONE, hreadyout=1 and hresp=00.
REQ-024 A read in DONE SHALL drive hrdata=mem[word index]; hrdata SHALL be 0 in every other cycle.
REQ-025 A write SHALL store hwdata into mem on the clock edge that ends DONE.
REQ-026 In ERR1, hreadyout=0 and hresp=01; ERR1 SHALL always be followed by ERR2.
REQ-027 In ERR2, hreadyout=1 and hresp=01; an illegal write SHALL NOT modify memory.
REQ-028 From DONE or ERR2, a new qualifying address phase on the same edge SHALL be accepted (back-to-back pipelining); otherwise the FSM SHALL return to IDLE.
REQ-029 Address phases presented while hreadyout=0 SHALL be ignored.
REQ-030 Write followed back-to-back by a read of the same address SHALL return the new data for every WAIT_STATES value, including 0.
REQ-031 The next state from IDLE SHALL depend only on the inputs sampled at the current edge; there SHALL be no combinational path from inputs to hreadyout or hresp.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL set: state IDLE, counter 0, hreadyout=1, hresp=00, hrdata=0, and all memory words to 0.
REQ-033 Reset asserted mid-transfer (in WAIT or ERR1) SHALL abort the transfer with no memory write; hreadyout=1 on the following cycle.
REQ-034 rst SHALL take priority over any simultaneous address phase.

Verification
REQ-035 WAIT_STATES=2, write 0xDEADBEEF to 0x0008 -> hreadyout=0 for 2 cycles, then 1 with hresp=00; mem[2]=0xDEADBEEF.
REQ-036 Read of 0x0008 after REQ-035 -> hrdata=0xDEADBEEF in the DONE cycle only, 0 elsewhere.
REQ-037 Read of 0x0006 (misaligned) and 0x0040 (out of range) -> each gives cycle 1 hreadyout=0/hresp=01 then cycle 2 hreadyout=1/hresp=01; memory unchanged.
REQ-038 WAIT_STATES=0, back-to-back write 0x12345678 to 0x0004 then read of 0x0004 -> read data phase returns 0x12345678, hreadyout stays 1 throughout.
REQ-039 rst=1 in the second wait cycle of a write to 0x000C -> next cycle hreadyout=1, hresp=00, and a following read of 0x000C returns 0.
REQ-040 htrans=01 (BUSY) or hsel=0 with a NONSEQ write -> no state change, memory unchanged, hreadyout=1.
